memory_dp_bypass: RTL and testbench
===================================

Name: memory_dp_bypass

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, single clock.
- Adds per-byte write enables, a read-valid handshake and selectable read latency (1 or 2).
- Adds write-first bypass on same-cycle address collision and a post-reset clear sweep.
- Drop-in storage for weight/activation buffers wherever a fixed-size memory is used today.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS entries, exactly (32 by default).
- RD_LATENCY, 1, cycles from accepted read request to rd_data_vld; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero every entry after reset; 0 = contents untouched by reset.

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low; reset==0 resets the block
- wr_vld  input  1  write request this cycle
- wr_address  input  ADDR_BITS  write address
- wr_data  input  WIDTH  write data
- wr_be  input  WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
- rd_vld  input  1  read request this cycle
- rd_address  input  ADDR_BITS  read address
- rd_data  output  WIDTH  read data, registered; holds its value between reads
- rd_data_vld  output  1  one-cycle pulse marking rd_data valid
- init_busy  output  1  clear sweep in progress; all requests ignored while high

Behaviour:
- Reset (sampled reset==0): rd_data=0, rd_data_vld=0, read pipeline flushed, init counter=0.
  - CLEAR_ON_RESET=1: FSM -> INIT, init_busy=1.
  - CLEAR_ON_RESET=0: FSM -> RUN, init_busy=0.
- FSM states:
  - INIT: writes WIDTH'd0 to entry init_cnt each cycle, then init_cnt+1.
  - INIT -> RUN: on the cycle init_cnt==DEPTH-1 is written, so init_busy is high for exactly DEPTH cycles after reset releases.
  - RUN: normal operation; stays in RUN until the next reset.
- During INIT: wr_vld and rd_vld are ignored; no write is performed and no rd_data_vld is produced. Requesters must wait for init_busy==0.
- Reset asserted mid-INIT restarts the sweep from entry 0.
- Write (RUN, wr_vld=1): for each byte i with wr_be[i]=1, mem[wr_address] byte i <= wr_data byte i; other bytes unchanged. wr_be=0 is a legal no-op.
- Read (RUN, rd_vld=1 in cycle t): the array is sampled at rd_address in cycle t.
  - RD_LATENCY=1: rd_data and rd_data_vld update at edge t+1.
  - RD_LATENCY=2: one extra register stage; update at edge t+2.
  - Back-to-back reads every cycle are supported, giving one result per cycle in order.
- Same-cycle collision (wr_vld & rd_vld & wr_address==rd_address): write-first. Enabled bytes return the new wr_data; disabled bytes return old contents.
- A write in a cycle after the read is sampled is NOT reflected in that read's data. This holds for RD_LATENCY=2 as well.
- No read in a cycle: rd_data_vld=0 and rd_data holds.
- Reset mid-read: in-flight reads are discarded; rd_data_vld stays 0 and rd_data=0.
- Addresses are always in range (DEPTH is a power of two); no wrap handling is needed.

Decomposition:
- Shared package memory_pkg:
  - typedef mem_wr_req_t {wr_vld, wr_address, wr_be}
  - typedef mem_rd_req_t {rd_vld, rd_address}
  - typedef init state enum {INIT, RUN}
  - localparam helper for byte-lane count
- One sub-module memory_init_ctrl: holds the FSM and init counter, and muxes the internal write port between the sweep and the user.
- Array, bypass merge and latency pipeline stay in the top.

Test Plan:
- Reset low 1 cycle, release -> init_busy high exactly 32 cycles; then read every address -> all 0x00000000 with rd_data_vld one cycle after each request (RD_LATENCY=1).
- Write 0xDEADBEEF to addr 5 with wr_be=4'hF; next cycle read 5 -> rd_data=0xDEADBEEF, rd_data_vld pulses once at t+1; with RD_LATENCY=2 the pulse is at t+2.
- Addr 7 holds 0x11223344; same cycle write 0xAABBCCDD, wr_be=4'b0101, and read 7 -> rd_data=0x11BB33DD; a subsequent read also returns 0x11BB33DD.
- Streaming reads of addr 0..31, rd_vld held high 32 cycles after a 0..31 pattern fill -> 32 consecutive rd_data_vld pulses with data 0..31 in order, no gaps.
- Requests during INIT (wr_vld to addr 3 with 0xFFFFFFFF, rd_vld to addr 3) -> no rd_data_vld; after init completes, read 3 returns 0.
- Reset asserted at sweep cycle 10, and separately at a cycle with a read in flight -> sweep restarts (init_busy high 32 more cycles); in-flight rd_data_vld suppressed and rd_data=0.

Source files
------------

// File: rtl/memory_dp_bypass_pkg.sv
// Shared types for the dual-port buffer RAM: request structs, init FSM states, lane helper.
package memory_pkg;

  // Struct fields are sized for the largest supported configuration and zero-padded.
  localparam int MEM_ADDR_MAX = 16;
  localparam int MEM_BE_MAX   = 16;

  typedef struct packed {
    logic                    wr_vld;
    logic [MEM_ADDR_MAX-1:0] wr_address;
    logic [MEM_BE_MAX-1:0]   wr_be;
  } mem_wr_req_t;

  typedef struct packed {
    logic                    rd_vld;
    logic [MEM_ADDR_MAX-1:0] rd_address;
  } mem_rd_req_t;

  typedef enum logic {INIT, RUN} init_state_t;

  function automatic int byte_lanes(int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/memory_dp_bypass_if.sv
// Requester <-> memory bundle: write port, read port, read response and init status.
interface memory_dp_bypass_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
);
  logic                   wr_vld;
  logic [ADDR_BITS-1:0]   wr_address;
  logic [WIDTH-1:0]       wr_data;
  logic [WIDTH/8-1:0]     wr_be;
  logic                   rd_vld;
  logic [ADDR_BITS-1:0]   rd_address;
  logic [WIDTH-1:0]       rd_data;
  logic                   rd_data_vld;
  logic                   init_busy;

  modport master (
    output wr_vld, wr_address, wr_data, wr_be, rd_vld, rd_address,
    input  rd_data, rd_data_vld, init_busy
  );

  modport slave (
    input  wr_vld, wr_address, wr_data, wr_be, rd_vld, rd_address,
    output rd_data, rd_data_vld, init_busy
  );
endinterface

// File: rtl/memory_dp_bypass_init_ctrl.sv
// Post-reset clear sweep FSM; owns the internal write port while the sweep runs.
module memory_init_ctrl
  import memory_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ADDR_BITS      = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  mem_wr_req_t       usr_wr,
  input  logic [WIDTH-1:0]  usr_wdata,
  output mem_wr_req_t       mem_wr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              init_busy
);
  localparam int NB = byte_lanes(WIDTH);
  localparam logic [ADDR_BITS-1:0] LAST = '1;

  init_state_t          state, state_nxt;
  logic [ADDR_BITS-1:0] init_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == LAST) state_nxt = RUN;
  end

  // Sweep owns the write port in INIT, so user writes are dropped rather than queued.
  always_comb begin
    init_busy = (state == INIT);
    mem_wr    = usr_wr;
    mem_wdata = usr_wdata;
    if (state == INIT) begin
      mem_wr                        = '0;
      mem_wr.wr_vld                 = 1'b1;
      mem_wr.wr_address[ADDR_BITS-1:0] = init_cnt;
      mem_wr.wr_be[NB-1:0]          = '1;
      mem_wdata                     = '0;
    end
  end

endmodule

// File: rtl/memory_dp_bypass.sv
// Simple-dual-port RAM with byte enables, write-first collision bypass,
// 1/2-cycle registered read latency and optional post-reset zero sweep.
module memory_dp_bypass
  import memory_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ADDR_BITS      = 5,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset,
  memory_dp_bypass_if.slave  bus
);
  localparam int NB     = byte_lanes(WIDTH);
  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int STAGES = RD_LATENCY - 1;

  logic [NB-1:0][7:0] mem [DEPTH];

  mem_wr_req_t          usr_wr, mem_wr;
  mem_rd_req_t          rd_req;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 init_busy;
  logic [ADDR_BITS-1:0] wa, ra;
  logic                 rd_fire, collide;
  logic [NB-1:0][7:0]   rd_word;

  logic [STAGES:0]             vld_pipe, vld_nxt;
  logic [STAGES:0][WIDTH-1:0]  dat_pipe, dat_nxt;

  always_comb begin
    usr_wr                           = '0;
    usr_wr.wr_vld                    = bus.wr_vld;
    usr_wr.wr_address[ADDR_BITS-1:0] = bus.wr_address;
    usr_wr.wr_be[NB-1:0]             = bus.wr_be;
    rd_req                           = '0;
    rd_req.rd_vld                    = bus.rd_vld;
    rd_req.rd_address[ADDR_BITS-1:0] = bus.rd_address;
  end

  memory_init_ctrl #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_init (
    .clk(clk), .reset(reset),
    .usr_wr(usr_wr), .usr_wdata(bus.wr_data),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .init_busy(init_busy)
  );

  assign wa = mem_wr.wr_address[ADDR_BITS-1:0];
  assign ra = rd_req.rd_address[ADDR_BITS-1:0];

  logic unused_hi;
  assign unused_hi = ^{mem_wr.wr_address >> ADDR_BITS, mem_wr.wr_be >> NB,
                       rd_req.rd_address >> ADDR_BITS};

  always_ff @(posedge clk) begin
    if (reset && mem_wr.wr_vld) begin
      for (int b = 0; b < NB; b++)
        if (mem_wr.wr_be[b]) mem[wa][b] <= mem_wdata[8*b +: 8];
    end
  end

  // Write-first: enabled lanes of a same-address write override the stored bytes.
  assign collide = mem_wr.wr_vld && (wa == ra);
  always_comb begin
    rd_word = mem[ra];
    for (int b = 0; b < NB; b++)
      if (collide && mem_wr.wr_be[b]) rd_word[b] = mem_wdata[8*b +: 8];
  end

  assign rd_fire = reset && !init_busy && rd_req.rd_vld;

  // Each stage only captures when its source is valid, so rd_data holds between reads.
  always_comb begin
    vld_nxt    = vld_pipe << 1;
    vld_nxt[0] = rd_fire;
    dat_nxt    = dat_pipe;
    if (rd_fire) dat_nxt[0] = rd_word;
    for (int s = 1; s <= STAGES; s++)
      if (vld_pipe[s-1]) dat_nxt[s] = dat_pipe[s-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= vld_nxt;
      dat_pipe <= dat_nxt;
    end
  end

  assign bus.rd_data     = dat_pipe[STAGES];
  assign bus.rd_data_vld = vld_pipe[STAGES];
  assign bus.init_busy   = init_busy;

endmodule

// File: tb/tb_memory_dp_bypass.sv
// Bench for memory_dp_bypass: latency-1 and latency-2 instances share stimulus
// and are checked against an array/queue reference model.
module tb_memory_dp_bypass;
  localparam int DEPTH = 32;

  typedef struct { int cyc; logic [31:0] d; } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_vld = 1'b0, rd_vld = 1'b0;
  logic [4:0]  wr_address = '0, rd_address = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;

  memory_dp_bypass_if #(.WIDTH(32), .ADDR_BITS(5)) bus1 ();
  memory_dp_bypass_if #(.WIDTH(32), .ADDR_BITS(5)) bus2 ();

  assign bus1.wr_vld = wr_vld;  assign bus2.wr_vld = wr_vld;
  assign bus1.wr_address = wr_address;  assign bus2.wr_address = wr_address;
  assign bus1.wr_data = wr_data;  assign bus2.wr_data = wr_data;
  assign bus1.wr_be = wr_be;  assign bus2.wr_be = wr_be;
  assign bus1.rd_vld = rd_vld;  assign bus2.rd_vld = rd_vld;
  assign bus1.rd_address = rd_address;  assign bus2.rd_address = rd_address;

  memory_dp_bypass #(.WIDTH(32), .ADDR_BITS(5), .RD_LATENCY(1), .CLEAR_ON_RESET(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  memory_dp_bypass #(.WIDTH(32), .ADDR_BITS(5), .RD_LATENCY(2), .CLEAR_ON_RESET(1))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic        vld_o [2];
  logic [31:0] dat_o [2];
  assign vld_o[0] = bus1.rd_data_vld;  assign dat_o[0] = bus1.rd_data;
  assign vld_o[1] = bus2.rd_data_vld;  assign dat_o[1] = bus2.rd_data;

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  int init_left = DEPTH;
  logic [31:0] mem_m [DEPTH];
  ev_t expq [2][$];
  ev_t obsq [2][$];

  task automatic idle();
    wr_vld = 1'b0; rd_vld = 1'b0; wr_be = '0;
  endtask

  task automatic clear_q();
    for (int d = 0; d < 2; d++) begin expq[d].delete(); obsq[d].delete(); end
  endtask

  // Reference model advances one cycle, then the clock edge; pulses are logged.
  task automatic step();
    logic [31:0] rv;
    int c = cyc;
    if (!reset) begin
      init_left = DEPTH;
      for (int d = 0; d < 2; d++)
        while (expq[d].size() > 0 && expq[d][$].cyc > c) void'(expq[d].pop_back());
    end else if (init_left > 0) begin
      mem_m[DEPTH - init_left] = 32'h0;
      init_left--;
    end else begin
      if (rd_vld) begin
        rv = mem_m[rd_address];
        if (wr_vld && wr_address == rd_address)
          for (int b = 0; b < 4; b++) if (wr_be[b]) rv[8*b +: 8] = wr_data[8*b +: 8];
        expq[0].push_back('{c + 1, rv});
        expq[1].push_back('{c + 2, rv});
      end
      if (wr_vld)
        for (int b = 0; b < 4; b++) if (wr_be[b]) mem_m[wr_address][8*b +: 8] = wr_data[8*b +: 8];
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) if (vld_o[d] === 1'b1) obsq[d].push_back('{cyc, dat_o[d]});
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (bus1.init_busy === 1'b1 && n < 100) begin n++; step(); end
  endtask

  task automatic test_reset();
    int n, c0;
    idle(); reset = 1'b0; step(); reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (vld_o[d] !== 1'b0 || dat_o[d] !== 32'h0) begin
        fails++; $display("FAIL reset_out dut%0d: vld=%b data=%h, want 0/0", d, vld_o[d], dat_o[d]);
      end
    end
    tests++;
    if (bus1.init_busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", bus1.init_busy); end
    wait_init(n);
    tests++;
    if (n !== DEPTH) begin fails++; $display("FAIL init_len: got %0d want %0d", n, DEPTH); end
    clear_q(); c0 = cyc;
    for (int a = 0; a < DEPTH; a++) begin rd_vld = 1'b1; rd_address = 5'(a); step(); end
    idle(); repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obsq[d].size() !== DEPTH) begin
        fails++; $display("FAIL cleared_cnt dut%0d: got %0d want %0d", d, obsq[d].size(), DEPTH);
      end else foreach (obsq[d][i]) begin
        tests++;
        if (obsq[d][i].d !== 32'h0 || obsq[d][i].cyc !== c0 + i + 1 + d) begin
          fails++; $display("FAIL cleared dut%0d[%0d]: got %h@%0d want 0@%0d", d, i, obsq[d][i].d, obsq[d][i].cyc, c0+i+1+d);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int c0;
    clear_q();
    wr_vld = 1'b1; wr_address = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF; step();
    idle(); rd_vld = 1'b1; rd_address = 5'd5; c0 = cyc; step();
    idle(); repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obsq[d].size() !== 1 || obsq[d][0].d !== 32'hDEADBEEF || obsq[d][0].cyc !== c0 + 1 + d) begin
        fails++; $display("FAIL wr_rd dut%0d: got %0d pulses first=%h, want 1 pulse DEADBEEF@%0d", d,
                          obsq[d].size(), (obsq[d].size() > 0) ? obsq[d][0].d : 32'hx, c0+1+d);
      end
    end
  endtask

  task automatic test_collision();
    int c0;
    wr_vld = 1'b1; wr_address = 5'd7; wr_data = 32'h11223344; wr_be = 4'hF; step();
    wr_address = 5'd9; wr_data = 32'h12345678; step();
    clear_q(); c0 = cyc;
    wr_address = 5'd7; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
    rd_vld = 1'b1; rd_address = 5'd7; step();
    wr_vld = 1'b0; step();
    idle(); repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obsq[d].size() !== 2) begin
        fails++; $display("FAIL collide_cnt dut%0d: got %0d want 2", d, obsq[d].size());
      end else foreach (obsq[d][i]) begin
        tests++;
        if (obsq[d][i].d !== 32'h11BB33DD || obsq[d][i].cyc !== c0 + i + 1 + d) begin
          fails++; $display("FAIL collide dut%0d[%0d]: got %h@%0d want 11BB33DD@%0d", d, i, obsq[d][i].d, obsq[d][i].cyc, c0+i+1+d);
        end
      end
      tests++;
      if (dat_o[d] !== 32'h11BB33DD) begin fails++; $display("FAIL hold dut%0d: got %h want 11BB33DD", d, dat_o[d]); end
    end
    // a write landing after the read is sampled must not leak into it
    clear_q();
    rd_vld = 1'b1; rd_address = 5'd9; step();
    rd_vld = 1'b0; wr_vld = 1'b1; wr_address = 5'd9; wr_data = 32'hCAFEF00D; wr_be = 4'hF; step();
    idle(); repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obsq[d].size() !== 1 || obsq[d][0].d !== 32'h12345678) begin
        fails++; $display("FAIL late_write dut%0d: got %0d pulses first=%h want 12345678", d,
                          obsq[d].size(), (obsq[d].size() > 0) ? obsq[d][0].d : 32'hx);
      end
    end
  endtask

  task automatic test_stream();
    int c0;
    for (int a = 0; a < DEPTH; a++) begin
      wr_vld = 1'b1; wr_address = 5'(a); wr_data = 32'(a); wr_be = 4'hF; step();
    end
    idle(); clear_q(); c0 = cyc;
    for (int a = 0; a < DEPTH; a++) begin rd_vld = 1'b1; rd_address = 5'(a); step(); end
    idle(); repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obsq[d].size() !== DEPTH) begin
        fails++; $display("FAIL stream_cnt dut%0d: got %0d want %0d", d, obsq[d].size(), DEPTH);
      end else foreach (obsq[d][i]) begin
        tests++;
        if (obsq[d][i].d !== 32'(i) || obsq[d][i].cyc !== c0 + i + 1 + d) begin
          fails++; $display("FAIL stream dut%0d[%0d]: got %h@%0d want %h@%0d", d, i, obsq[d][i].d, obsq[d][i].cyc, 32'(i), c0+i+1+d);
        end
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int k = 0; k < 300; k++) begin
      wr_vld = 1'($urandom); wr_address = 5'($urandom_range(0, 7));
      wr_data = $urandom; wr_be = 4'($urandom);
      rd_vld = 1'($urandom); rd_address = 5'($urandom_range(0, 7));
      step();
    end
    idle(); repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obsq[d].size() !== expq[d].size()) begin
        fails++; $display("FAIL rand_cnt dut%0d: got %0d want %0d", d, obsq[d].size(), expq[d].size());
      end else foreach (obsq[d][i]) begin
        tests++;
        if (obsq[d][i].d !== expq[d][i].d || obsq[d][i].cyc !== expq[d][i].cyc) begin
          fails++; $display("FAIL rand dut%0d[%0d]: got %h@%0d want %h@%0d", d, i, obsq[d][i].d, obsq[d][i].cyc, expq[d][i].d, expq[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_init_requests();
    int n;
    idle(); reset = 1'b0; step(); reset = 1'b1;
    clear_q();
    wr_vld = 1'b1; wr_address = 5'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_vld = 1'b1; rd_address = 5'd3;
    wait_init(n);
    idle(); step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obsq[d].size() !== 0) begin fails++; $display("FAIL init_rd dut%0d: got %0d pulses want 0", d, obsq[d].size()); end
    end
    rd_vld = 1'b1; rd_address = 5'd3; step();
    idle(); repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obsq[d].size() !== 1 || obsq[d][0].d !== 32'h0) begin
        fails++; $display("FAIL init_wr dut%0d: got %0d pulses first=%h want 1 pulse 0", d,
                          obsq[d].size(), (obsq[d].size() > 0) ? obsq[d][0].d : 32'hx);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    idle(); reset = 1'b0; step(); reset = 1'b1;
    repeat (10) step();
    reset = 1'b0; step(); reset = 1'b1;
    wait_init(n);
    tests++;
    if (n !== DEPTH) begin fails++; $display("FAIL restart_len: got %0d want %0d", n, DEPTH); end
    wr_vld = 1'b1; wr_address = 5'd12; wr_data = 32'h5555AAAA; wr_be = 4'hF; step();
    idle(); clear_q();
    rd_vld = 1'b1; rd_address = 5'd12; step();
    reset = 1'b0; step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (vld_o[d] !== 1'b0 || dat_o[d] !== 32'h0) begin
        fails++; $display("FAIL flush dut%0d: vld=%b data=%h want 0/0", d, vld_o[d], dat_o[d]);
      end
    end
    reset = 1'b1; idle();
    wait_init(n);
    tests++;
    if (obsq[0].size() !== 1 || obsq[0][0].d !== 32'h5555AAAA) begin
      fails++; $display("FAIL pre_reset dut0: got %0d pulses want 1 of 5555AAAA", obsq[0].size());
    end
    tests++;
    if (obsq[1].size() !== 0) begin fails++; $display("FAIL inflight dut1: got %0d pulses want 0", obsq[1].size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_stream();
    test_random();
    test_init_requests();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
